// File: rtl/uart_pack_decoder_pkg.sv
// Shared encodings for the UART packet decoder:
// FSM states, command bit positions, mode/speed values.
package uart_pack_decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_MODE  = 2;
  localparam int CMD_CH_LO = 3;
  localparam int CMD_CH_HI = 6;
  localparam int CMD_RSVD  = 7;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_REPEAT  = 1'b1;
  localparam logic SPEED_LOW    = 1'b0;
  localparam logic SPEED_HIGH   = 1'b1;

  function automatic logic [3:0] cmd_channel(
    input logic [7:0] cmd
  );
    return cmd[CMD_CH_HI:CMD_CH_LO];
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte timeout counter; saturates at
// TIMEOUT_CLK-1 and flags expiry there.
module byte_timeout #(
  parameter int TIMEOUT_CLK = 20_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW =
    (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'(TIMEOUT_CLK - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_pack_decoder.sv
// Assembles UART bytes into pattern/freq/command
// packets and issues start/stop strobes downstream.
module uart_pack_decoder
  import uart_pack_decoder_pkg::*;
#(
  parameter int DATA_BIT    = 8,
  parameter int PACK_NUM    = 3,
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CLK = 20_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_BIT-1:0] i_data,
  input  logic                i_rx_done_tick,
  input  logic                i_done_tick,
  output logic [DATA_BIT-1:0] o_out_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic [3:0]          o_channel,
  output logic                o_mode,
  output logic                o_start_tick,
  output logic                o_stop_tick,
  output logic                o_busy,
  output logic                o_err_tick
);

  localparam int IW =
    (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam logic [IW-1:0] LAST = IW'(PACK_NUM - 1);

  state_t              r_state, w_state_n;
  logic [IW-1:0]       r_idx, w_idx_n, w_widx;
  logic [DATA_BIT-1:0] r_pat, r_frq;
  logic [DATA_BIT-1:0] r_out, r_freq;
  logic [3:0]          r_ch;
  logic                r_mode, r_busy;
  logic                r_start, r_stop, r_err;
  logic                w_start_n, w_stop_n, w_err_n;
  logic                w_busy_n, w_latch;
  logic                w_last, w_expired, w_to_clr, w_to_en;
  logic [7:0]          w_cmd;
  logic [3:0]          w_ch;
  logic                w_bad, w_rej, w_stp, w_sta, w_pre;

  assign w_cmd = i_data[7:0];
  assign w_ch  = cmd_channel(w_cmd);
  assign w_bad = w_cmd[CMD_RSVD]
               | ({1'b0, w_ch} >= 5'(NUM_CH));
  // Mutually exclusive command classes; stop beats start.
  assign w_rej = w_bad;
  assign w_stp = !w_bad & w_cmd[CMD_STOP];
  assign w_sta = !w_bad & !w_cmd[CMD_STOP]
               & w_cmd[CMD_START];
  assign w_pre = !w_bad & !w_cmd[CMD_STOP]
               & !w_cmd[CMD_START];

  assign w_last = i_rx_done_tick
                & (r_state == S_RECV)
                & (r_idx == LAST);
  assign w_widx = (r_state == S_RECV) ? r_idx : '0;

  assign w_to_clr = (r_state != S_RECV) | i_rx_done_tick;
  assign w_to_en  = (r_state == S_RECV);

  byte_timeout #(
    .TIMEOUT_CLK (TIMEOUT_CLK)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_to_clr),
    .i_en      (w_to_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_start_n = 1'b0;
    w_stop_n  = 1'b0;
    w_err_n   = 1'b0;
    w_latch   = 1'b0;
    w_busy_n  = i_done_tick ? 1'b0 : r_busy;
    unique case (r_state)
      S_RECV: begin
        if (i_rx_done_tick) begin
          w_idx_n = r_idx + 1'b1;
          if (w_last) begin
            w_state_n = S_ISSUE;
            w_idx_n   = '0;
            unique case (1'b1)
              w_rej: w_err_n = 1'b1;
              w_stp: begin
                w_stop_n = 1'b1;
                w_busy_n = 1'b0;
                w_latch  = 1'b1;
              end
              w_sta & r_busy: w_err_n = 1'b1;
              w_sta & !r_busy: begin
                w_start_n = 1'b1;
                w_busy_n  = 1'b1;
                w_latch   = 1'b1;
              end
              w_pre: w_latch = 1'b1;
            endcase
          end
        end else if (w_expired) begin
          w_err_n   = 1'b1;
          w_state_n = S_IDLE;
          w_idx_n   = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        if (i_rx_done_tick) begin
          w_state_n = S_RECV;
          w_idx_n   = IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pat   <= '0;
      r_frq   <= '0;
      r_out   <= '0;
      r_freq  <= '0;
      r_ch    <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_busy  <= w_busy_n;
      r_start <= w_start_n;
      r_stop  <= w_stop_n;
      r_err   <= w_err_n;
      if (i_rx_done_tick && !w_last) begin
        if (w_widx == '0) r_pat <= i_data;
        else              r_frq <= i_data;
      end
      if (w_latch) begin
        r_out  <= r_pat;
        r_freq <= r_frq;
        r_ch   <= w_ch;
        r_mode <= w_cmd[CMD_MODE];
      end
    end
  end

  assign o_out_pattern  = r_out;
  assign o_freq_pattern = r_freq;
  assign o_channel      = r_ch;
  assign o_mode         = r_mode;
  assign o_start_tick   = r_start;
  assign o_stop_tick    = r_stop;
  assign o_busy         = r_busy;
  assign o_err_tick     = r_err;

endmodule

// File: tb/tb_uart_pack_decoder.sv
// Scoreboard bench: packet-level reference model
// queues expected strobes; monitor checks them.
module tb_uart_pack_decoder;

  localparam int NCH = 4;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_rx_done_tick = 1'b0;
  logic       i_done_tick = 1'b0;
  logic [7:0] o_out_pattern, o_freq_pattern;
  logic [3:0] o_channel;
  logic       o_mode, o_start_tick, o_stop_tick;
  logic       o_busy, o_err_tick;

  uart_pack_decoder #(
    .DATA_BIT    (8),
    .PACK_NUM    (3),
    .NUM_CH      (NCH),
    .TIMEOUT_CLK (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_data         (i_data),
    .i_rx_done_tick (i_rx_done_tick),
    .i_done_tick    (i_done_tick),
    .o_out_pattern  (o_out_pattern),
    .o_freq_pattern (o_freq_pattern),
    .o_channel      (o_channel),
    .o_mode         (o_mode),
    .o_start_tick   (o_start_tick),
    .o_stop_tick    (o_stop_tick),
    .o_busy         (o_busy),
    .o_err_tick     (o_err_tick)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] stb;
    logic [7:0] out, freq;
    logic [3:0] ch;
    logic       mode, busy;
  } ev_t;

  ev_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [7:0] m_out = '0, m_freq = '0;
  logic [3:0] m_ch = '0;
  logic       m_mode = 1'b0, m_busy = 1'b0;

  function automatic void check(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(
    input int c, input logic [2:0] stb
  );
    ev_t e;
    e.cyc = c; e.stb = stb;
    e.out = m_out; e.freq = m_freq;
    e.ch = m_ch; e.mode = m_mode; e.busy = m_busy;
    sbq.push_back(e);
  endfunction

  // Reference: what a complete packet should do,
  // given the command rules and the current busy flag.
  function automatic void model_pkt(
    input logic [7:0] b0, b1, b2,
    input bit done, input int c
  );
    int ch;
    ch = int'(b2[6:3]);
    if (b2[7] || ch >= NCH) begin
      if (done) m_busy = 1'b0;
      push_ev(c, 3'b001);
    end else if (b2[1]) begin
      m_out = b0; m_freq = b1;
      m_ch = b2[6:3]; m_mode = b2[2];
      m_busy = 1'b0;
      push_ev(c, 3'b010);
    end else if (b2[0] && m_busy) begin
      if (done) m_busy = 1'b0;
      push_ev(c, 3'b001);
    end else if (b2[0]) begin
      m_out = b0; m_freq = b1;
      m_ch = b2[6:3]; m_mode = b2[2];
      m_busy = 1'b1;
      push_ev(c, 3'b100);
    end else begin
      m_out = b0; m_freq = b1;
      m_ch = b2[6:3]; m_mode = b2[2];
      if (done) m_busy = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (o_start_tick | o_stop_tick | o_err_tick) begin
      if (sbq.size() == 0) begin
        check("spurious_strobe",
              {29'd0, o_start_tick, o_stop_tick, o_err_tick},
              32'd0);
      end else begin
        ev_t e;
        e = sbq.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_kind",
              {o_start_tick, o_stop_tick, o_err_tick}, e.stb);
        check("ev_out", o_out_pattern, e.out);
        check("ev_freq", o_freq_pattern, e.freq);
        check("ev_ch", o_channel, e.ch);
        check("ev_mode", o_mode, e.mode);
        check("ev_busy", o_busy, e.busy);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(
    input logic [7:0] b, input bit done
  );
    i_data = b;
    i_rx_done_tick = 1'b1;
    i_done_tick = done;
    @(negedge clk);
    i_rx_done_tick = 1'b0;
    i_done_tick = 1'b0;
    i_data = 8'($urandom);
  endtask

  task automatic send_pkt(
    input logic [7:0] b0, b1, b2,
    input bit done, input int g0, g1
  );
    drive_byte(b0, 1'b0);
    idle(g0);
    drive_byte(b1, 1'b0);
    idle(g1);
    model_pkt(b0, b1, b2, done, cyc + 1);
    drive_byte(b2, done);
  endtask

  task automatic send_partial(input int k);
    int last;
    for (int i = 0; i < k; i++) begin
      last = cyc + 1;
      drive_byte(8'($urandom), 1'b0);
    end
    push_ev(last + TO, 3'b001);
    idle(TO + 4);
  endtask

  task automatic pulse_done();
    i_done_tick = 1'b1;
    m_busy = 1'b0;
    @(negedge clk);
    i_done_tick = 1'b0;
  endtask

  task automatic check_state(input string nm);
    check({nm, "_out"}, o_out_pattern, m_out);
    check({nm, "_freq"}, o_freq_pattern, m_freq);
    check({nm, "_ch"}, o_channel, m_ch);
    check({nm, "_mode"}, o_mode, m_mode);
    check({nm, "_busy"}, o_busy, m_busy);
  endtask

  task automatic model_reset();
    m_out = '0; m_freq = '0; m_ch = '0;
    m_mode = 1'b0; m_busy = 1'b0;
  endtask

  initial begin
    idle(3);
    check_state("reset");
    rst_n = 1'b1;
    idle(2);

    send_pkt(8'h55, 8'h55, 8'h05, 1'b0, 5, 5);
    check_state("start55");
    idle(3);

    send_pkt(8'hAA, 8'hFF, 8'h0D, 1'b0, 2, 2);
    check_state("busy_reject");
    idle(2);
    pulse_done();
    idle(1);
    send_pkt(8'hAA, 8'hFF, 8'h0D, 1'b0, 0, 0);
    check_state("resend");
    idle(2);

    pulse_done();
    send_partial(2);
    check_state("timeout");
    send_pkt(8'h55, 8'hFF, 8'h01, 1'b0, 3, 1);
    check_state("after_to");
    idle(2);

    send_pkt(8'h00, 8'h00, 8'h03, 1'b0, 1, 1);
    check_state("stop");
    idle(2);
    send_pkt(8'h00, 8'h00, 8'h21, 1'b0, 1, 1);
    check_state("bad_ch");
    send_pkt(8'h11, 8'h22, 8'h0C, 1'b0, 0, 0);
    check_state("preload");
    send_pkt(8'h33, 8'h44, 8'h8D, 1'b0, 0, 0);
    check_state("rsvd");
    idle(2);

    drive_byte(8'h77, 1'b0);
    drive_byte(8'h66, 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    model_reset();
    check_state("mid_reset");
    rst_n = 1'b1;
    idle(2);
    send_pkt(8'h12, 8'h34, 8'h05, 1'b1, 1, 1);
    check_state("done_coincide");
    idle(2);
    send_pkt(8'h9A, 8'hBC, 8'h0B, 1'b0, 0, 0);
    send_pkt(8'h21, 8'h43, 8'h19, 1'b0, 0, 0);
    check_state("back_to_back");
    idle(2);

    for (int i = 0; i < 200; i++) begin
      int r;
      logic [7:0] cmd;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        send_partial($urandom_range(1, 2));
        check_state("rnd_to");
      end else if (r < 20) begin
        pulse_done();
      end else begin
        cmd = 8'($urandom);
        cmd[7] = ($urandom_range(0, 9) == 0);
        cmd[6:3] = 4'($urandom_range(0, 5));
        send_pkt(8'($urandom), 8'($urandom), cmd,
                 ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 10),
                 $urandom_range(0, 10));
        check_state("rnd_pkt");
        idle($urandom_range(0, 3));
      end
    end

    idle(TO + 10);
    check("queue_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
